fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
- Parametrised next-generation instruction fetch stage.
- Decouples PC generation from a handshaked, variable-latency instruction memory and from decode.
- Keeps up to FIFO_DEPTH requests in flight or buffered, so fetch continues while decode stalls.
- On redirect (branch/jump target), flushes queued and in-flight instructions and restarts fetch at the new PC. Sits between the PC/next-PC logic and the decode/sign-extend path.

Parameters:
- ADDRESS_WIDTH, 32, PC and memory address width.
- INSTR_WIDTH, 32, instruction word width.
- FIFO_DEPTH, 4, prefetch buffer entries and maximum total in-flight plus buffered requests; power of two, ≥2.
- RESET_PC, 0, fetch address after reset; must be PC_STEP-aligned.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset. Named without the n_ prefix because it is active-high.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDRESS_WIDTH  new fetch address; bits [1:0] forced to 0 internally.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDRESS_WIDTH  fetch address (= fetch_pc).
- imem_rsp_valid  in  1  one response per accepted request, in order, ≥1 cycle after acceptance.
- imem_rsp_data  in  INSTR_WIDTH  fetched instruction.
- instr_valid  out  1  head instruction available.
- instr_ready  in  1  decode consumes head.
- instr  out  INSTR_WIDTH  head instruction; 0 when !instr_valid.
- instr_pc  out  ADDRESS_WIDTH  PC of head instruction; 0 when !instr_valid.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high. All state changes on the rising edge of clk.
- State:
  - fetch_pc: next request address.
  - rsp_pc: PC of the next kept response.
  - outstanding: accepted, not-yet-returned, kept requests.
  - discard: in-flight responses to drop.
  - FIFO of {instr, pc}, with occupancy count.
  - Counter widths: clog2(FIFO_DEPTH)+1.
- Reset:
  - fetch_pc = rsp_pc = RESET_PC.
  - outstanding = discard = count = 0.
  - imem_req_valid = 0 and instr_valid = 0 during and after the reset cycle until the first non-reset cycle.
  - imem_req_addr = RESET_PC.
  - imem_rsp_valid is ignored during reset. The instruction memory shares reset and drops pre-reset requests.
- Credit rule: imem_req_valid = !reset && !redirect && (outstanding + discard + count < FIFO_DEPTH). The FIFO never overflows; push needs no full check.
- Request handshake (valid && ready): fetch_pc += PC_STEP, wrapping modulo 2^ADDRESS_WIDTH. outstanding += 1.
- Response handling:
  - If discard > 0: response dropped, discard −= 1.
  - Otherwise: {imem_rsp_data, rsp_pc} pushed, rsp_pc += PC_STEP, outstanding −= 1.
- Output:
  - instr_valid = (count != 0), registered FIFO state with no bypass. Minimum response-to-instr_valid latency is 1 cycle.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle: count unchanged. Empty FIFO with push: no pop that cycle.
- Redirect (highest priority, single cycle):
  - fetch_pc = rsp_pc = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}.
  - FIFO flushed, count = 0. outstanding = 0.
  - discard = discard + outstanding − imem_rsp_valid. Any response arriving that cycle is dropped.
  - imem_req_valid is 0 that cycle; the first request to the new PC is issued the next cycle.
  - A pop handshake in the redirect cycle counts as completed. Decode owns that instruction's squash.
- Back-to-back redirects: each re-targets; discard accumulates correctly.
- Simultaneous request accept and response in one cycle: outstanding unchanged.
- Decode stall (instr_ready = 0): FIFO fills, then requests stop by credit. No instruction is lost or reordered.
- Memory stall (imem_req_ready = 0): imem_req_addr and imem_req_valid hold stable until accepted, unless redirect or reset occurs.

Test Plan:
- Reset release, RESET_PC=0, memory ready, latency 1, decode always ready → requests 0x0, 0x4, 0x8…. instr_pc sequence 0x0, 0x4, 0x8 with matching data. instr_valid first high 2 cycles after the first accept.
- instr_ready=0 for 10 cycles, FIFO_DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0, count=4. Release → 4 instructions in PC order, then fetch resumes at 0x10.
- 3 requests in flight (latency 3), redirect to 0x100 → the 3 stale responses are dropped. Next instr_pc is 0x100. imem_req_addr is 0x100 the cycle after redirect.
- Redirect with redirect_pc=0x203 coincident with a response → response dropped, fetch restarts at 0x200, discard accounts for the coincident response.
- Random imem_req_ready and latency 1–5, random instr_ready, 1000 instructions → output PCs strictly sequential except at redirects. No duplicates or drops. outstanding+discard+count ≤ 4 always.
- Assert reset mid-stream with a full FIFO → next cycle instr_valid=0, imem_req_valid=0. After release the first request is to RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch stage with a credit-limited prefetch queue.
// Requests go to a handshaked, variable-latency instruction memory. Responses
// come back in order and are buffered for decode. The total of in-flight,
// to-be-discarded and buffered entries never exceeds FIFO_DEPTH, so the buffer
// cannot overflow. A redirect flushes everything and restarts fetch; responses
// that belong to requests issued before the redirect are counted and dropped.
module fetch_prefetch_queue #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = {ADDRESS_WIDTH{1'b0}},
    parameter int PC_STEP       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0]   imem_rsp_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_WIDTH-1:0]   instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;  // counter width
    localparam int PW = $clog2(FIFO_DEPTH);      // pointer width
    localparam int SW = CW + 2;                  // headroom for summed counters

    logic [ADDRESS_WIDTH-1:0] fetch_pc_r;
    logic [ADDRESS_WIDTH-1:0] rsp_pc_r;
    logic [CW-1:0]            outstanding_r;
    logic [CW-1:0]            discard_r;
    logic [CW-1:0]            count_r;
    logic [PW-1:0]            wr_ptr_r;
    logic [PW-1:0]            rd_ptr_r;
    logic [INSTR_WIDTH-1:0]   fifo_instr_r [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] fifo_pc_r    [FIFO_DEPTH];

    logic [SW-1:0]            credit_used_s;
    logic [SW-1:0]            redirect_discard_s;
    logic [ADDRESS_WIDTH-1:0] redirect_base_s;
    logic [ADDRESS_WIDTH-1:0] step_s;
    logic                     req_fire_s;
    logic                     rsp_keep_s;
    logic                     rsp_drop_s;
    logic                     pop_s;

    // Request credit, handshake decode and redirect bookkeeping values.
    always_comb begin
        step_s          = ADDRESS_WIDTH'(PC_STEP);
        redirect_base_s = redirect_pc & {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};
        credit_used_s   = SW'(outstanding_r) + SW'(discard_r) + SW'(count_r);
        if (reset || redirect) begin
            imem_req_valid = 1'b0;
        end else begin
            imem_req_valid = (credit_used_s < SW'(FIFO_DEPTH));
        end
        imem_req_addr = fetch_pc_r;
        req_fire_s    = imem_req_valid && imem_req_ready;
        rsp_keep_s    = imem_rsp_valid && (discard_r == CW'(0));
        rsp_drop_s    = imem_rsp_valid && (discard_r != CW'(0));
        pop_s         = instr_valid && instr_ready;
        // Stale responses still owed by memory after the redirect; a response
        // arriving in the redirect cycle itself is one of them and is dropped.
        redirect_discard_s = SW'(discard_r) + SW'(outstanding_r);
        if (imem_rsp_valid && (redirect_discard_s != SW'(0))) begin
            redirect_discard_s = redirect_discard_s - SW'(1);
        end else begin
            redirect_discard_s = redirect_discard_s;
        end
    end

    // Head of the queue; outputs are zeroed whenever nothing is buffered.
    always_comb begin
        instr_valid = (count_r != CW'(0));
        if (instr_valid) begin
            instr    = fifo_instr_r[rd_ptr_r];
            instr_pc = fifo_pc_r[rd_ptr_r];
        end else begin
            instr    = {INSTR_WIDTH{1'b0}};
            instr_pc = {ADDRESS_WIDTH{1'b0}};
        end
    end

    // Fetch/response PCs, counters and queue pointers; redirect beats everything but reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= CW'(0);
            discard_r     <= CW'(0);
            count_r       <= CW'(0);
            wr_ptr_r      <= PW'(0);
            rd_ptr_r      <= PW'(0);
        end else if (redirect) begin
            fetch_pc_r    <= redirect_base_s;
            rsp_pc_r      <= redirect_base_s;
            outstanding_r <= CW'(0);
            discard_r     <= CW'(redirect_discard_s);
            count_r       <= CW'(0);
            wr_ptr_r      <= PW'(0);
            rd_ptr_r      <= PW'(0);
        end else begin
            if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + step_s;
            end
            if (rsp_keep_s) begin
                rsp_pc_r <= rsp_pc_r + step_s;
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            outstanding_r <= outstanding_r + CW'(req_fire_s) - CW'(rsp_keep_s);
            discard_r     <= discard_r - CW'(rsp_drop_s);
            count_r       <= count_r + CW'(rsp_keep_s) - CW'(pop_s);
        end
    end

    // Queue storage: kept responses are written with the PC they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_r[i] <= {INSTR_WIDTH{1'b0}};
                fifo_pc_r[i]    <= {ADDRESS_WIDTH{1'b0}};
            end
        end else if (!redirect && rsp_keep_s) begin
            fifo_instr_r[wr_ptr_r] <= imem_rsp_data;
            fifo_pc_r[wr_ptr_r]    <= rsp_pc_r;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: a directed cycle table with hand-computed
// outputs, followed by sequences driven through a small in-order memory model.
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_prefetch_queue dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic rst; logic rdr; logic [31:0] rpc; logic rrdy; logic rspv; logic [31:0] rspd; logic ir;
        logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_instr; logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rdr, input logic [31:0] rpc,
                                input logic rrdy, input logic rspv, input logic [31:0] rspd,
                                input logic ir, input logic e_rv, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.rdr = rdr; v.rpc = rpc; v.rrdy = rrdy; v.rspv = rspv; v.rspd = rspd;
        v.ir = ir; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    vec_t tbl [15];

    // ---------------- memory model for sequences ----------------
    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t        mq[$];
    logic [31:0] acc_addr[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_acc = 0;
    int          n_pop = 0;
    logic [31:0] exp_pc = 32'h0;
    logic        drv_reset = 1'b0;
    logic        drv_redirect = 1'b0;
    logic [31:0] drv_rpc = 32'h0;
    logic        drv_ready = 1'b0;
    logic        drv_ir = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        last_rv = 1'b0;
    logic        last_iv = 1'b0;
    logic [31:0] last_addr = 32'h0;

    // One clock cycle: drive at negedge, sample/check 1 time unit later, update model after posedge.
    task automatic step();
        logic give;
        logic fire;
        logic popped;
        int   lat;
        int   d;
        @(negedge clk);
        reset = drv_reset; redirect = drv_redirect; redirect_pc = drv_rpc;
        imem_req_ready = drv_ready; instr_ready = drv_ir;
        give = 1'b0;
        imem_rsp_data = 32'h0;
        if (!drv_reset && mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
                give = 1'b1;
                imem_rsp_data = dat(mq[0].addr);
            end
        end
        imem_rsp_valid = give;
        #1;
        last_rv = imem_req_valid; last_iv = instr_valid; last_addr = imem_req_addr;
        if (prev_stall && !drv_redirect && !drv_reset) begin
            chk("hold_valid", {31'b0, imem_req_valid}, 32'h1);
            chk("hold_addr", imem_req_addr, prev_addr);
        end
        prev_stall = imem_req_valid && !drv_ready;
        prev_addr  = imem_req_addr;
        fire   = imem_req_valid && drv_ready;
        popped = instr_valid && drv_ir && !drv_reset;
        if (popped) begin
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_instr", instr, dat(exp_pc));
        end
        @(posedge clk);
        if (drv_reset) begin
            mq.delete();
            exp_pc = 32'h0;
            prev_stall = 1'b0;
            last_due = cyc;
        end else begin
            if (give) void'(mq.pop_front());
            if (fire) begin
                lat = $urandom_range(lat_max, lat_min);
                d = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                mq.push_back('{imem_req_addr, d});
                last_due = d;
                n_acc++;
                acc_addr.push_back(imem_req_addr);
            end
            if (popped) begin
                n_pop++;
                exp_pc = exp_pc + 32'd4;
            end
            if (drv_redirect) exp_pc = drv_rpc & 32'hFFFF_FFFC;
        end
        cyc++;
    endtask

    task automatic do_reset();
        drv_reset = 1'b1; drv_redirect = 1'b0; drv_ir = 1'b0; drv_ready = 1'b0;
        step();
        step();
        drv_reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int guard;
        //            rst rdr rpc           rrdy rspv rspd           ir   rv  addr          iv  instr          pc
        tbl[0]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          0,   0, 32'h0,       0, 32'h0,          32'h0);
        tbl[1]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h0,       0, 32'h0,          32'h0);
        tbl[2]  = mk(0, 0, 32'h0,          1, 1, 32'hC0DE_0000,  1,   1, 32'h4,       0, 32'h0,          32'h0);
        tbl[3]  = mk(0, 0, 32'h0,          1, 1, 32'hC0DE_0004,  1,   1, 32'h8,       1, 32'hC0DE_0000,  32'h0);
        tbl[4]  = mk(0, 0, 32'h0,          1, 1, 32'hC0DE_0008,  1,   1, 32'hC,       1, 32'hC0DE_0004,  32'h4);
        tbl[5]  = mk(0, 1, 32'h203,        1, 1, 32'hC0DE_000C,  1,   0, 32'h10,      1, 32'hC0DE_0008,  32'h8);
        tbl[6]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h200,     0, 32'h0,          32'h0);
        tbl[7]  = mk(0, 0, 32'h0,          0, 1, 32'hC0DE_0200,  1,   1, 32'h204,     0, 32'h0,          32'h0);
        tbl[8]  = mk(0, 0, 32'h0,          0, 0, 32'h0,          0,   1, 32'h204,     1, 32'hC0DE_0200,  32'h200);
        tbl[9]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          1,   1, 32'h204,     1, 32'hC0DE_0200,  32'h200);
        tbl[10] = mk(0, 1, 32'h100,        0, 0, 32'h0,          1,   0, 32'h208,     0, 32'h0,          32'h0);
        tbl[11] = mk(0, 0, 32'h0,          1, 1, 32'hC0DE_0204,  1,   1, 32'h100,     0, 32'h0,          32'h0);
        tbl[12] = mk(0, 0, 32'h0,          0, 1, 32'hC0DE_0100,  1,   1, 32'h104,     0, 32'h0,          32'h0);
        tbl[13] = mk(0, 0, 32'h0,          0, 0, 32'h0,          1,   1, 32'h104,     1, 32'hC0DE_0100,  32'h100);
        tbl[14] = mk(0, 0, 32'h0,          0, 0, 32'h0,          1,   1, 32'h104,     0, 32'h0,          32'h0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            reset = tbl[i].rst; redirect = tbl[i].rdr; redirect_pc = tbl[i].rpc;
            imem_req_ready = tbl[i].rrdy; imem_rsp_valid = tbl[i].rspv;
            imem_rsp_data = tbl[i].rspd; instr_ready = tbl[i].ir;
            #1;
            chk($sformatf("row%0d req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].e_rv});
            chk($sformatf("row%0d req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("row%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].e_iv});
            chk($sformatf("row%0d instr", i), instr, tbl[i].e_instr);
            chk($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].e_pc);
        end

        // Decode stall: credit stops fetch at four, then drains in order and resumes at 0x10.
        do_reset();
        lat_min = 1; lat_max = 1; drv_ready = 1'b1; drv_ir = 1'b0;
        n_acc = 0; acc_addr.delete();
        repeat (10) step();
        chk("stall_accepts", 32'(n_acc), 32'd4);
        chk("stall_req_valid", {31'b0, last_rv}, 32'h0);
        chk("stall_instr_valid", {31'b0, last_iv}, 32'h1);
        drv_ir = 1'b1;
        target = n_pop + 4;
        guard = 0;
        while ((n_pop < target || n_acc < 5) && guard < 40) begin
            step();
            guard++;
        end
        chk("stall_drain", {31'b0, (n_pop >= target)}, 32'h1);
        chk("resume_accepts", {31'b0, (n_acc >= 5)}, 32'h1);
        if (n_acc >= 5) chk("resume_addr", acc_addr[4], 32'h10);

        // Latency 3 with three requests in flight, then redirect to 0x100.
        do_reset();
        lat_min = 3; lat_max = 3; drv_ready = 1'b1; drv_ir = 1'b1;
        guard = 0;
        while (mq.size() < 3 && guard < 20) begin
            step();
            guard++;
        end
        chk("inflight3", {31'b0, (mq.size() >= 3)}, 32'h1);
        drv_redirect = 1'b1; drv_rpc = 32'h100;
        step();
        drv_redirect = 1'b0;
        step();
        chk("redir_req_valid", {31'b0, last_rv}, 32'h1);
        chk("redir_addr", last_addr, 32'h100);
        target = n_pop + 3;
        guard = 0;
        while (n_pop < target && guard < 40) begin
            step();
            guard++;
        end
        chk("redir_pops", {31'b0, (n_pop >= target)}, 32'h1);

        // Reset in the middle of a stream with the queue full.
        lat_min = 1; lat_max = 1; drv_ir = 1'b0;
        repeat (12) step();
        chk("full_iv", {31'b0, last_iv}, 32'h1);
        chk("full_rv", {31'b0, last_rv}, 32'h0);
        drv_reset = 1'b1;
        step();
        chk("rst_cycle_rv", {31'b0, last_rv}, 32'h0);
        step();
        chk("rst_next_iv", {31'b0, last_iv}, 32'h0);
        chk("rst_next_rv", {31'b0, last_rv}, 32'h0);
        drv_reset = 1'b0; drv_ir = 1'b1;
        step();
        chk("rst_first_rv", {31'b0, last_rv}, 32'h1);
        chk("rst_first_addr", last_addr, 32'h0);

        // Random memory readiness, latency 1..5, decode readiness and occasional redirects.
        do_reset();
        lat_min = 1; lat_max = 5;
        target = n_pop + 1000;
        guard = 0;
        while (n_pop < target && guard < 30000) begin
            drv_ready = ($urandom_range(3, 0) != 0);
            drv_ir = ($urandom_range(3, 0) != 0);
            drv_redirect = ($urandom_range(99, 0) == 0);
            drv_rpc = 32'($urandom_range(65535, 0));
            step();
            guard++;
        end
        drv_redirect = 1'b0;
        chk("random_progress", {31'b0, (n_pop >= target)}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
